mux_scan_sampler: RTL and testbench

Sequential scanner that drives the 3-bit `selector` of the 6-input channel multiplexer and reads back its single-bit output. It steps through channels 0..NUM_CH-1, waits a programmable settle time on each, samples the mux output, and assembles one parallel snapshot word. The word is delivered downstream over a valid/ready handshake, either once per `start` or continuously.

---
 rtl/mux_scan_sampler.sv | 132 +++++++++++++
 tb/tb_mux_scan_sampler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sampler.sv
// Walks the channel multiplexer selector through every channel, samples each one
// after a settle time, and offers the assembled snapshot over a valid/ready handshake.
module mux_scan_sampler #(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned DWELL  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              mux_in,
    output logic [2:0]        selector,
    output logic              busy,
    output logic [NUM_CH-1:0] snap,
    output logic              snap_valid,
    input  logic              snap_ready
);

    localparam int unsigned CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [2:0]       CH_LAST  = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         ch_q, ch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  samp_q, samp_d;
    logic [NUM_CH-1:0]  snap_q, snap_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            samp_q  <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            samp_q  <= samp_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        samp_d  = samp_q;
        snap_d  = snap_q;
        valid_d = valid_q;
        busy_d  = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    ch_d    = '0;
                    cnt_d   = '0;
                    samp_d  = '0;
                    busy_d  = 1'b1;
                end
            end

            ST_SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (ch_q == 3'(i)) begin
                            samp_d[i] = mux_in;
                        end
                    end
                    // Last channel: publish including the bit captured on this edge
                    if (ch_q == CH_LAST) begin
                        snap_d  = samp_d;
                        valid_d = 1'b1;
                        ch_d    = '0;
                        state_d = ST_HOLD;
                    end else begin
                        ch_d = ch_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (snap_ready) begin
                    valid_d = 1'b0;
                    ch_d    = '0;
                    cnt_d   = '0;
                    if (continuous) begin
                        state_d = ST_SCAN;
                        samp_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                ch_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Selector is the channel register itself, so it never leaves 0..NUM_CH-1
    assign selector   = ch_q;
    assign busy       = busy_q;
    assign snap       = snap_q;
    assign snap_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Self-checking bench for mux_scan_sampler: a pattern-driven mux model feeds the DUT and
// expected selector/valid/snapshot timing is derived from channel count and dwell time.
module tb_mux_scan_sampler;

    localparam int unsigned NCH   = 6;
    localparam int unsigned DW    = 4;
    localparam int unsigned LEN   = NCH * DW;
    localparam int unsigned NCH8  = 8;
    localparam int unsigned DW8   = 2;
    localparam int unsigned LEN8  = NCH8 * DW8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           start, continuous, snap_ready, mux_in;
    logic [2:0]     selector;
    logic           busy, snap_valid;
    logic [NCH-1:0] snap;
    logic [7:0]     pat;

    logic            start8, cont8, ready8, mux_in8;
    logic [2:0]      sel8;
    logic            busy8, valid8;
    logic [NCH8-1:0] snap8;
    logic [7:0]      pat8;

    int n_checks = 0;
    int n_errors = 0;

    // Multiplexer model: output is the pattern bit addressed by the selector
    assign mux_in  = pat[selector];
    assign mux_in8 = pat8[sel8];

    mux_scan_sampler #(.NUM_CH(NCH), .DWELL(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .mux_in(mux_in), .selector(selector), .busy(busy), .snap(snap),
        .snap_valid(snap_valid), .snap_ready(snap_ready)
    );

    mux_scan_sampler #(.NUM_CH(NCH8), .DWELL(DW8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .continuous(cont8),
        .mux_in(mux_in8), .selector(sel8), .busy(busy8), .snap(snap8),
        .snap_valid(valid8), .snap_ready(ready8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] p;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if ({selector, busy, snap, snap_valid} !== 11'd0) begin
                n_errors++;
                $display("FAIL idle_zero c=%0d got sel=%0d busy=%b snap=%b valid=%b exp all 0",
                         c, selector, busy, snap, snap_valid);
            end
        end
        // Fill the snapshot so the async reset has something to clear
        p = 6'($urandom) | 6'b000001;
        pat = {2'b00, p};
        snap_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (LEN + 2) tick();
        n_checks++;
        if (snap !== p || snap_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_hold got snap=%b valid=%b exp snap=%b valid=1", snap, snap_valid, p);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({selector, busy, snap, snap_valid} !== 11'd0) begin
            n_errors++;
            $display("FAIL async_reset got sel=%0d busy=%b snap=%b valid=%b exp all 0",
                     selector, busy, snap, snap_valid);
        end
        #1 rst_n = 1'b1;
    endtask

    // One single-shot scan; bp = cycles of backpressure, poke = pulse start mid-scan
    task automatic scan_once(input logic [5:0] p, input int bp, input bit poke);
        int exp_sel;
        pat = {2'b00, p};
        continuous = 1'b0;
        snap_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (selector !== 3'd0 || busy !== 1'b1 || snap_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL scan_start got sel=%0d busy=%b valid=%b exp sel=0 busy=1 valid=0",
                     selector, busy, snap_valid);
        end
        for (int j = 1; j <= int'(LEN); j++) begin
            start = poke && (j == 6 || j == 13);
            tick();
            start = 1'b0;
            exp_sel = (j < int'(LEN)) ? j / int'(DW) : 0;
            n_checks++;
            if (selector !== 3'(exp_sel) || busy !== 1'b1 || snap_valid !== (j == int'(LEN))) begin
                n_errors++;
                $display("FAIL scan_step j=%0d got sel=%0d busy=%b valid=%b exp sel=%0d busy=1 valid=%b",
                         j, selector, busy, snap_valid, exp_sel, (j == int'(LEN)));
            end
        end
        n_checks++;
        if (snap !== p) begin
            n_errors++;
            $display("FAIL snap_value got %b exp %b", snap, p);
        end
        snap_ready = (bp == 0);
        for (int b = 0; b < bp; b++) begin
            tick();
            n_checks++;
            if (snap !== p || snap_valid !== 1'b1 || selector !== 3'd0 || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL backpressure b=%0d got snap=%b valid=%b sel=%0d busy=%b exp snap=%b valid=1 sel=0 busy=1",
                         b, snap, snap_valid, selector, busy, p);
            end
        end
        snap_ready = 1'b1;
        tick();
        n_checks++;
        if (snap_valid !== 1'b0 || busy !== 1'b0 || selector !== 3'd0) begin
            n_errors++;
            $display("FAIL accept got valid=%b busy=%b sel=%0d exp valid=0 busy=0 sel=0",
                     snap_valid, busy, selector);
        end
        snap_ready = 1'b0;
    endtask

    task automatic test_single();
        scan_once(6'b101101, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        scan_once(6'b101101, 7, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            scan_once(6'($urandom), int'($urandom_range(0, 5)), 1'b0);
        end
    endtask

    task automatic test_ignored_start();
        scan_once(6'($urandom), 1, 1'b1);
    endtask

    task automatic test_continuous();
        pat = 8'b00101101;
        continuous = 1'b1;
        snap_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 49; j++) begin
            if (j == 50 - 1) continuous = 1'b1;
            tick();
            if (j == 25) pat = 8'b00010011;
            n_checks++;
            if (snap_valid !== (j == 24 || j == 49) || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL cont_valid j=%0d got valid=%b busy=%b exp valid=%b busy=1",
                         j, snap_valid, busy, (j == 24 || j == 49));
            end
            if (j == 24) begin
                n_checks++;
                if (snap !== 6'b101101) begin
                    n_errors++;
                    $display("FAIL cont_snap1 got %b exp 101101", snap);
                end
            end
        end
        n_checks++;
        if (snap !== 6'b010011) begin
            n_errors++;
            $display("FAIL cont_snap2 got %b exp 010011", snap);
        end
        continuous = 1'b0;
        tick();
        n_checks++;
        if (snap_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL cont_stop got valid=%b busy=%b exp 0 0", snap_valid, busy);
        end
        snap_ready = 1'b0;
    endtask

    task automatic test_reset_midscan();
        pat = 8'h2A;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (selector !== 3'd0 || busy !== 1'b0 || snap_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midscan_reset got sel=%0d busy=%b valid=%b exp 0 0 0",
                     selector, busy, snap_valid);
        end
        #2 rst_n = 1'b1;
        scan_once(6'b111111, 0, 1'b0);
    endtask

    task automatic test_params();
        logic [7:0] p;
        int exp_sel;
        int max_sel;
        p = 8'($urandom);
        pat8 = p;
        ready8 = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        max_sel = 0;
        for (int j = 1; j <= int'(LEN8); j++) begin
            tick();
            exp_sel = (j < int'(LEN8)) ? j / int'(DW8) : 0;
            if (int'(sel8) > max_sel) max_sel = int'(sel8);
            n_checks++;
            if (sel8 !== 3'(exp_sel) || valid8 !== (j == int'(LEN8)) || busy8 !== 1'b1) begin
                n_errors++;
                $display("FAIL p8_step j=%0d got sel=%0d valid=%b busy=%b exp sel=%0d valid=%b busy=1",
                         j, sel8, valid8, busy8, exp_sel, (j == int'(LEN8)));
            end
        end
        n_checks++;
        if (snap8 !== p || max_sel != 7) begin
            n_errors++;
            $display("FAIL p8_snap got snap=%b max_sel=%0d exp snap=%b max_sel=7", snap8, max_sel, p);
        end
        tick();
        n_checks++;
        if (valid8 !== 1'b0 || busy8 !== 1'b0) begin
            n_errors++;
            $display("FAIL p8_accept got valid=%b busy=%b exp 0 0", valid8, busy8);
        end
        ready8 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        snap_ready = 1'b0;
        pat = 8'h00;
        start8 = 1'b0;
        cont8 = 1'b0;
        ready8 = 1'b0;
        pat8 = 8'h00;
        #12;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_continuous();
        test_reset_midscan();
        test_ignored_start();
        test_params();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
